// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: drives program-memory address, buffers one
// instruction for the decoder and applies jump/call/return/skip/halt via a return stack.
module pc_sequencer #(
    parameter int unsigned            ADR_W       = 5,
    parameter int unsigned            DATA_W      = 16,
    parameter int unsigned            STACK_DEPTH = 4,
    parameter logic [ADR_W-1:0]       RESET_VEC   = '0
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    output logic [ADR_W-1:0]                 pm_adr_o,
    input  logic [DATA_W-1:0]                pm_data_i,
    output logic [DATA_W-1:0]                instr_o,
    output logic                             instr_valid_o,
    input  logic                             instr_ready_i,
    input  logic                             jmp_en_i,
    input  logic                             call_en_i,
    input  logic                             ret_en_i,
    input  logic                             skip_en_i,
    input  logic [ADR_W-1:0]                 jmp_adr_i,
    input  logic                             halt_req_i,
    input  logic                             run_i,
    output logic                             halted_o,
    output logic                             stk_err_o,
    output logic [$clog2(STACK_DEPTH):0]     sp_o
);

    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
    localparam int unsigned SP_W  = IDX_W + 1;

    typedef enum logic [1:0] {
        S_FETCH,
        S_RUN,
        S_HALT,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [ADR_W-1:0]    pc_q, pc_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                valid_q, valid_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic [ADR_W-1:0]    stack_q [STACK_DEPTH];

    logic                push;
    logic                consume;
    logic                stk_empty;
    logic                stk_full;
    logic [IDX_W-1:0]    push_idx;
    logic [IDX_W-1:0]    top_idx;
    logic [ADR_W-1:0]    pc_inc;

    assign consume   = valid_q & instr_ready_i;
    assign stk_empty = (sp_q == '0);
    assign stk_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign push_idx  = sp_q[IDX_W-1:0];
    assign top_idx   = IDX_W'(sp_q - SP_W'(1));
    assign pc_inc    = pc_q + ADR_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        sp_d    = sp_q;
        push    = 1'b0;

        case (state_q)
            S_FETCH: begin
                instr_d = pm_data_i;
                pc_d    = pc_inc;
                valid_d = 1'b1;
                state_d = S_RUN;
            end

            S_RUN: begin
                if (consume) begin
                    if (ret_en_i) begin
                        valid_d = 1'b0;
                        if (stk_empty) begin
                            state_d = S_ERR;
                        end else begin
                            pc_d    = stack_q[top_idx];
                            sp_d    = sp_q - SP_W'(1);
                            state_d = S_FETCH;
                        end
                    end else if (call_en_i) begin
                        valid_d = 1'b0;
                        if (stk_full) begin
                            state_d = S_ERR;
                        end else begin
                            push    = 1'b1;
                            pc_d    = jmp_adr_i;
                            sp_d    = sp_q + SP_W'(1);
                            state_d = S_FETCH;
                        end
                    end else if (jmp_en_i) begin
                        pc_d    = jmp_adr_i;
                        valid_d = 1'b0;
                        state_d = S_FETCH;
                    end else if (skip_en_i) begin
                        pc_d    = pc_inc;
                        valid_d = 1'b0;
                        state_d = S_FETCH;
                    end else if (halt_req_i) begin
                        valid_d = 1'b0;
                        state_d = S_HALT;
                    end else begin
                        instr_d = pm_data_i;
                        pc_d    = pc_inc;
                    end
                end
            end

            S_HALT: begin
                valid_d = 1'b0;
                // Resume performs the fetch in the same edge so valid follows run by one cycle.
                if (run_i) begin
                    instr_d = pm_data_i;
                    pc_d    = pc_inc;
                    valid_d = 1'b1;
                    state_d = S_RUN;
                end
            end

            S_ERR: begin
                valid_d = 1'b0;
            end

            default: begin
                state_d = S_ERR;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_VEC;
            instr_q <= '0;
            valid_q <= 1'b0;
            sp_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            sp_q    <= sp_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            stack_q[push_idx] <= pc_q;
        end
    end

    assign pm_adr_o      = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign halted_o      = (state_q == S_HALT);
    assign stk_err_o     = (state_q == S_ERR);
    assign sp_o          = sp_q;

endmodule
